// File: rtl/bounce_pkg.sv
// Shared definitions for the switch-bounce emulator and its stimulus helpers.
//   - bounce_state_e : FSM encoding of the bounce generator
//   - LfsrTaps       : Galois feedback mask for x^16+x^14+x^13+x^11
//   - DefaultSeed    : nonzero LFSR reset value
//   - lfsr_next()    : one right-shift Galois LFSR step
package bounce_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StBnew   = 2'b01,
    StBold   = 2'b10,
    StSettle = 2'b11
  } bounce_state_e;

  localparam logic [15:0] LfsrTaps    = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, advancing every clock cycle.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset, loads SEED
//   q     : current LFSR state
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DefaultSeed
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sw_bounce_gen.sv
// Bouncing mechanical switch emulator. On each change of clean_in it drives a
// pseudo-random burst of glitch pairs (new level, then old level) on sw_out and
// then holds the new level for a settle period before pulsing done_tick.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   clean_in  : ideal switch level
//   enable    : 1 = emulate bounce, 0 = sw_out follows clean_in (1 cycle latency)
//   sw_out    : emulated noisy switch level (registered)
//   busy      : high during burst and settle phases (registered)
//   done_tick : one-cycle pulse when the settle phase completes (registered)
module sw_bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned PRESC_W      = 10,
  parameter int unsigned DUR_W        = 3,
  parameter int unsigned PAIR_W       = 2,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter logic [15:0] SEED         = DefaultSeed
) (
  input  logic clk,
  input  logic reset,
  input  logic clean_in,
  input  logic enable,
  output logic sw_out,
  output logic busy,
  output logic done_tick
);

  // One counter serves both glitch phases and the settle phase.
  localparam int unsigned SettleW  = $clog2(SETTLE_TICKS + 1);
  localparam int unsigned CntW     = (DUR_W + 1 > SettleW) ? DUR_W + 1 : SettleW;
  localparam int unsigned PairCntW = PAIR_W + 1;

  bounce_state_e        state_q, state_d;
  logic                 target_q, target_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PairCntW-1:0]  pairs_q, pairs_d;
  logic                 sw_out_q, sw_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          lfsr_val;
  logic                 tick;
  logic                 phase_end;
  logic [CntW-1:0]      dur_load;
  logic [PairCntW-1:0]  pair_load;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_val)
  );

  // Only a few LFSR bits feed the burst shape; fold the rest into a dummy.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_val;

  assign tick      = (presc_q == '0);
  // The load cycle always reloads, so a tick there never shortens a phase.
  assign phase_end = tick && (cnt_q == CntW'(1));
  assign dur_load  = CntW'(lfsr_val[DUR_W-1:0]) + CntW'(1);
  assign pair_load = PairCntW'(lfsr_val[15 -: PAIR_W]) + PairCntW'(1);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    pairs_d  = pairs_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!enable) begin
          target_d = clean_in;
        end else if (clean_in != target_q) begin
          target_d = clean_in;
          pairs_d  = pair_load;
          cnt_d    = dur_load;
          state_d  = StBnew;
        end
      end
      StBnew: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (phase_end) begin
          cnt_d   = dur_load;
          state_d = StBold;
        end else if (tick) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBold: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (phase_end) begin
          if (pairs_q > PairCntW'(1)) begin
            pairs_d = pairs_q - PairCntW'(1);
            cnt_d   = dur_load;
            state_d = StBnew;
          end else begin
            cnt_d   = CntW'(SETTLE_TICKS);
            state_d = StSettle;
          end
        end else if (tick) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSettle: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (phase_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tick) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    sw_out_d = (state_d == StBold) ? ~target_d : target_d;
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      pairs_q  <= '0;
      sw_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      presc_q  <= presc_q + PRESC_W'(1);
      cnt_q    <= cnt_d;
      pairs_q  <= pairs_d;
      sw_out_q <= sw_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sw_out    = sw_out_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Scoreboard bench for sw_bounce_gen (PRESC_W=2, DUR_W=2, PAIR_W=1, SETTLE_TICKS=2).
// The stimulus process queues one expected event per transaction; the monitor
// pops and checks whenever the DUT completes, aborts or follows.
module tb_sw_bounce_gen;

  localparam int KDone   = 0;
  localparam int KAbort  = 1;
  localparam int KFollow = 2;
  localparam int DebStable = 20;  // longer than any single glitch phase (16 cycles)
  localparam int MinBurst  = 13;  // 4 ticks, first tick possibly in the start cycle
  localparam int MaxBurst  = 74;

  typedef struct {
    int   kind;
    logic level;
    int   t_issue;
    int   t_abort;
    int   start_mode;  // 0: busy one cycle after issue, 1: one cycle after previous done
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clean_in = 1'b0;
  logic enable = 1'b1;
  logic sw_out;
  logic busy;
  logic done_tick;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -10;
  bit   mon_en = 1'b0;
  bit   deb_chk = 1'b0;
  logic deb_out = 1'b0;
  int   deb_cnt = 0;
  exp_t exp_q[$];
  logic deb_q[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  bit   in_burst = 1'b0;
  int   edges = 0;
  int   start_cyc = 0;
  logic deb_lvl;

  sw_bounce_gen #(
    .PRESC_W      (2),
    .DUR_W        (2),
    .PAIR_W       (1),
    .SETTLE_TICKS (2),
    .SEED         (16'hACE1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clean_in  (clean_in),
    .enable    (enable),
    .sw_out    (sw_out),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input logic lvl, input int mode);
    exp_t e;
    e.kind       = kind;
    e.level      = lvl;
    e.t_issue    = cyc;
    e.t_abort    = 0;
    e.start_mode = mode;
    exp_q.push_back(e);
  endtask

  // The burst queued last is about to be cut short by the current stimulus.
  task automatic abort_back(input logic lvl);
    exp_t e;
    e         = exp_q.pop_back();
    e.kind    = KAbort;
    e.level   = lvl;
    e.t_abort = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int n);
    int tgt = done_cnt + n;
    for (int i = 0; i < 100 * n && done_cnt < tgt; i++) @(negedge clk);
    check("done_wait", done_cnt, tgt);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        deb_out = sw_out;
        deb_cnt = 0;
      end else begin
        // Reference debouncer: accept a level once stable for DebStable samples.
        if (sw_out !== deb_out) begin
          deb_cnt++;
          if (deb_cnt >= DebStable) begin
            deb_out = sw_out;
            deb_cnt = 0;
            if (deb_chk) begin
              if (deb_q.size() == 0) begin
                check("deb_unexpected_edge", deb_q.size(), 1);
              end else begin
                deb_lvl = deb_q.pop_front();
                check("deb_level", int'(deb_out), int'(deb_lvl));
              end
            end
          end
        end else begin
          deb_cnt = 0;
        end

        if (busy && !in_burst) begin
          in_burst  = 1'b1;
          edges     = 0;
          start_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_burst", exp_q.size(), 1);
          end else begin
            mon_e = exp_q[0];
            check("start_is_burst", int'(mon_e.kind == KFollow), 0);
            if (mon_e.start_mode == 0) check("start_latency", cyc - mon_e.t_issue, 1);
            else check("start_after_done", cyc - last_done_cyc, 1);
          end
        end

        if (in_burst && sw_out !== mon_prev) begin
          edges++;
        end else if (!in_burst && !busy && sw_out !== mon_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_follow", exp_q.size(), 1);
          end else begin
            mon_e = exp_q.pop_front();
            check("follow_kind", mon_e.kind, KFollow);
            check("follow_level", int'(sw_out), int'(mon_e.level));
            check("follow_latency", cyc - mon_e.t_issue, 1);
          end
        end

        if (done_tick) begin
          done_cnt++;
          last_done_cyc = cyc;
          check("done_without_busy", int'(busy), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", exp_q.size(), 1);
          end else begin
            mon_e = exp_q.pop_front();
            check("done_kind", mon_e.kind, KDone);
            check("done_level", int'(sw_out), int'(mon_e.level));
            check("done_edges", edges, (edges <= 3) ? 3 : 5);
            check("burst_min_len", int'(cyc - start_cyc >= MinBurst), 1);
            check("burst_max_len", int'(cyc - start_cyc <= MaxBurst), 1);
          end
          in_burst = 1'b0;
        end else if (in_burst && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_abort", exp_q.size(), 1);
          end else begin
            mon_e = exp_q.pop_front();
            check("abort_kind", mon_e.kind, KAbort);
            check("abort_level", int'(sw_out), int'(mon_e.level));
            check("abort_latency", cyc - mon_e.t_abort, 1);
          end
          in_burst = 1'b0;
        end
      end
      mon_prev = sw_out;
    end
  end

  initial begin : stim
    logic lvl;
    int   k;
    // Reset held for three edges.
    reset = 1'b1; enable = 1'b1; clean_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sw_out", int'(sw_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_tick), 0);
    check("rst_lfsr", int'(dut.lfsr_val), 16'hACE1);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("quiet_sw_out", int'(sw_out), 0);
    check("quiet_busy", int'(busy), 0);

    // Single burst 0 -> 1.
    clean_in = 1'b1;
    push_exp(KDone, 1'b1, 0);
    wait_done(1);

    // Revert during burst: 1 -> 0, back to 1 ten cycles later.
    @(negedge clk);
    clean_in = 1'b0;
    push_exp(KDone, 1'b0, 0);
    repeat (10) @(negedge clk);
    clean_in = 1'b1;
    push_exp(KDone, 1'b1, 1);
    wait_done(2);
    repeat (3) @(negedge clk);
    check("revert_final", int'(sw_out), 1);

    // Bypass: sw_out follows clean_in one cycle later, no bursts.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    clean_in = 1'b0; push_exp(KFollow, 1'b0, 0);
    repeat (3) @(negedge clk);
    clean_in = 1'b1; push_exp(KFollow, 1'b1, 0);
    repeat (3) @(negedge clk);
    clean_in = 1'b0; push_exp(KFollow, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Enable drop while the old level is being shown.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    clean_in = 1'b1;
    push_exp(KDone, 1'b1, 0);
    k = 0;
    while (k < 100 && !(busy && sw_out == 1'b0)) begin
      @(negedge clk);
      k++;
    end
    check("bold_reached", int'(busy && sw_out == 1'b0), 1);
    enable = 1'b0;
    abort_back(1'b1);
    repeat (30) @(negedge clk);
    check("drop_sw_out", int'(sw_out), 1);

    // Reset in the middle of a burst toward 0.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    clean_in = 1'b0;
    push_exp(KDone, 1'b0, 0);
    repeat (6) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    abort_back(1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);

    // End-to-end through the reference debouncer.
    deb_chk = 1'b1;
    lvl = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lvl = ~lvl;
      clean_in = lvl;
      push_exp(KDone, lvl, 0);
      deb_q.push_back(lvl);
      wait_done(1);
      repeat (24 + $urandom_range(0, 8)) @(negedge clk);
      check("deb_track", int'(deb_out), int'(lvl));
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("deb_q_drained", deb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
